ghash_ctrl: RTL and testbench

GHASH sequencer for the AES-GCM authentication path. It instantiates one combinational `gfmul` and drives it every cycle to accumulate Y ← (Y ⊕ Xᵢ)·H over the AAD blocks and then the ciphertext blocks. It zero-pads partial last blocks, counts bit lengths, and appends the len(A)||len(C) block itself. It then presents the 128-bit GHASH result to the tag stage, where it is XORed with E(K, J0).

---
 rtl/ghash_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ghash_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_ctrl.sv
// GHASH sequencer for AES-GCM: absorbs AAD then ciphertext blocks into Y = (Y ^ X) * H,
// appends the len(A)||len(C) block and presents the final GHASH value for the tag stage.

// Combinational GF(2^128) multiply, bit 0 = MSB, standard GCM right-shift algorithm.
module gfmul (
  input  logic [0:127] iCtext,
  input  logic [0:127] iHashkey,
  input  logic [0:127] iR,
  output logic [0:127] oResult
);

  logic [0:127] z [0:128];
  logic [0:127] v [0:127];

  assign z[0] = '0;
  assign v[0] = iHashkey;

  generate
    for (genvar gi = 0; gi < 128; gi++) begin : g_bit
      assign z[gi+1] = iCtext[gi] ? (z[gi] ^ v[gi]) : z[gi];
      if (gi < 127) begin : g_shift
        // Shift towards the x^127 end; reduce when the top coefficient falls off.
        assign v[gi+1] = v[gi][127] ? ((v[gi] >> 1) ^ iR) : (v[gi] >> 1);
      end
    end
  endgenerate

  assign oResult = z[128];

endmodule

module ghash_ctrl (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [0:127] iHashkey,
  input  logic [0:127] iData,
  input  logic [4:0]   iBytes,
  input  logic         iType,
  input  logic         iLast,
  input  logic         iValid,
  output logic         oReady,
  output logic [0:127] oHash,
  output logic [0:127] oTag,
  output logic         oTagValid,
  output logic         oErr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LEN, S_DONE} state_t;

  localparam logic [0:127] GCM_R = {8'hE1, 120'd0};

  state_t       state_reg, state_next;
  logic [0:127] y_reg, y_next;
  logic [0:127] h_reg, h_next;
  logic [63:0]  len_a_reg, len_a_next;
  logic [63:0]  len_c_reg, len_c_next;
  logic         err_reg, err_next;
  logic         seen_ct_reg, seen_ct_next;
  logic         part_a_reg, part_a_next;
  logic         part_c_reg, part_c_next;

  logic         bad_bytes;
  logic [4:0]   nbytes;
  logic [63:0]  nbits;
  logic [0:127] data_masked;
  logic [0:127] mul_in;
  logic [0:127] mul_out;
  logic         partial;

  // Out-of-range byte counts are absorbed as full blocks.
  assign bad_bytes = (iBytes == 5'd0) || (iBytes > 5'd16);
  assign nbytes    = bad_bytes ? 5'd16 : iBytes;
  assign nbits     = 64'({nbytes, 3'b000});
  assign partial   = (nbytes != 5'd16);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mask
      assign data_masked[8*gi +: 8] = (5'(gi) < nbytes) ? iData[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign mul_in = (state_reg == S_LEN) ? (y_reg ^ {len_a_reg, len_c_reg})
                                       : (y_reg ^ data_masked);

  gfmul u_gfmul (
    .iCtext  (mul_in),
    .iHashkey(h_reg),
    .iR      (GCM_R),
    .oResult (mul_out)
  );

  always_comb begin
    state_next   = state_reg;
    y_next       = y_reg;
    h_next       = h_reg;
    len_a_next   = len_a_reg;
    len_c_next   = len_c_reg;
    err_next     = err_reg;
    seen_ct_next = seen_ct_reg;
    part_a_next  = part_a_reg;
    part_c_next  = part_c_reg;

    if (iStart) begin
      // Start aborts anything in flight; a block presented alongside it is dropped.
      state_next   = S_ACCUM;
      h_next       = iHashkey;
      y_next       = '0;
      len_a_next   = '0;
      len_c_next   = '0;
      err_next     = 1'b0;
      seen_ct_next = 1'b0;
      part_a_next  = 1'b0;
      part_c_next  = 1'b0;
    end else begin
      case (state_reg)
        S_ACCUM: begin
          if (iValid) begin
            y_next = mul_out;
            if (bad_bytes) err_next = 1'b1;
            if (iType) begin
              len_c_next   = len_c_reg + nbits;
              seen_ct_next = 1'b1;
              if (part_c_reg) err_next = 1'b1;
              part_c_next  = partial && !iLast;
            end else begin
              len_a_next  = len_a_reg + nbits;
              if (seen_ct_reg || part_a_reg) err_next = 1'b1;
              part_a_next = partial && !iLast;
            end
            if (iLast) state_next = S_LEN;
          end
        end
        S_LEN: begin
          y_next     = mul_out;
          state_next = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg   <= S_IDLE;
      y_reg       <= '0;
      h_reg       <= '0;
      len_a_reg   <= '0;
      len_c_reg   <= '0;
      err_reg     <= 1'b0;
      seen_ct_reg <= 1'b0;
      part_a_reg  <= 1'b0;
      part_c_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      y_reg       <= y_next;
      h_reg       <= h_next;
      len_a_reg   <= len_a_next;
      len_c_reg   <= len_c_next;
      err_reg     <= err_next;
      seen_ct_reg <= seen_ct_next;
      part_a_reg  <= part_a_next;
      part_c_reg  <= part_c_next;
    end
  end

  assign oReady    = (state_reg == S_ACCUM);
  assign oTagValid = (state_reg == S_DONE);
  assign oTag      = (state_reg == S_DONE) ? y_reg : '0;
  assign oHash     = y_reg;
  assign oErr      = err_reg;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl: stimulus queues expected hashes/tags, a monitor
// compares them whenever a block is accepted or the tag becomes valid.
module tb_ghash_ctrl;

  logic         iClk = 1'b0;
  logic         iRst, iStart, iType, iLast, iValid;
  logic [0:127] iHashkey, iData;
  logic [4:0]   iBytes;
  logic         oReady, oTagValid, oErr;
  logic [0:127] oHash, oTag;

  always #5 iClk = ~iClk;

  ghash_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iHashkey(iHashkey),
    .iData(iData), .iBytes(iBytes), .iType(iType), .iLast(iLast),
    .iValid(iValid), .oReady(oReady), .oHash(oHash), .oTag(oTag),
    .oTagValid(oTagValid), .oErr(oErr)
  );

  int checks = 0;
  int passes = 0;

  logic [0:127] hash_q[$];
  string        hname_q[$];
  logic [0:127] tag_q[$];

  // Reference state of the message currently being hashed.
  logic [0:127] mh, my;
  logic [63:0]  mla, mlc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [0:127] gmul(input logic [0:127] a, input logic [0:127] b);
    logic [0:127] z = '0;
    logic [0:127] v = b;
    logic lsb;
    for (int i = 0; i < 128; i++) begin
      if (a[i]) z ^= v;
      lsb = v[127];
      v = v >> 1;
      if (lsb) v[0:7] = v[0:7] ^ 8'hE1;
    end
    return z;
  endfunction

  function automatic int eff_bytes(input logic [4:0] b);
    return (b == 5'd0 || b > 5'd16) ? 16 : int'(b);
  endfunction

  function automatic logic [0:127] tb_mask(input logic [0:127] d, input logic [4:0] b);
    logic [0:127] r = d;
    for (int k = eff_bytes(b); k < 16; k++) r[8*k +: 8] = 8'h00;
    return r;
  endfunction

  // Monitor: acceptance is sampled on the rising edge, results compared on the falling edge.
  int cyc = 0;
  int last_cyc = -100;
  bit acc_seen = 0;
  bit tv_prev = 0;

  always @(posedge iClk) begin
    cyc++;
    acc_seen = iValid && oReady && !iStart && !iRst;
    if (acc_seen && iLast) last_cyc = cyc;
  end

  always @(negedge iClk) begin
    if (acc_seen) begin
      if (hash_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_accept: got accept at cycle %0d required none", cyc);
      end else begin
        check(hname_q.pop_front(), oHash, hash_q.pop_front());
      end
    end
    if (oTagValid && !tv_prev) begin
      if (tag_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tag: got tag %h required none", oTag);
      end else begin
        check("tag", oTag, tag_q.pop_front());
        check("tag_latency", 128'(cyc - last_cyc), 128'(1));
      end
    end
    tv_prev = oTagValid;
  end

  task automatic do_start(input logic [0:127] h, input bit with_data);
    @(negedge iClk);
    iStart = 1'b1; iHashkey = h;
    iValid = with_data; iData = {$urandom, $urandom, $urandom, $urandom};
    iBytes = 5'd16; iType = 1'b0; iLast = 1'b0;
    @(posedge iClk);
    #1 iStart = 1'b0; iValid = 1'b0;
    mh = h; my = '0; mla = '0; mlc = '0;
    $display("start H=%h", h);
  endtask

  task automatic send_block(input logic [0:127] d, input logic [4:0] b, input logic typ,
                            input logic last, input int gap, input bit use_hand,
                            input logic [0:127] hand, input string name);
    logic [0:127] exp;
    int w;
    repeat (gap) begin
      @(negedge iClk);
      iValid = 1'b0; iData = {$urandom, $urandom, $urandom, $urandom};
    end
    exp = use_hand ? hand : gmul(my ^ tb_mask(d, b), mh);
    hash_q.push_back(exp);
    hname_q.push_back(name);
    my = exp;
    if (typ) mlc += 64'(8 * eff_bytes(b));
    else     mla += 64'(8 * eff_bytes(b));
    @(negedge iClk);
    iData = d; iBytes = b; iType = typ; iLast = last; iValid = 1'b1;
    w = 0;
    while (!oReady && w < 10) begin
      @(negedge iClk);
      w++;
    end
    if (w == 10) begin
      checks++;
      $display("FAIL %s_ready_timeout: got oReady=0 required 1", name);
    end
    @(posedge iClk);
    #1 iValid = 1'b0;
    $display("block %s type=%0d bytes=%0d last=%0d data=%h exp=%h", name, typ, b, last, d, exp);
  endtask

  task automatic push_tag(input bit use_hand, input logic [0:127] hand, output logic [0:127] t);
    t = use_hand ? hand : gmul(my ^ {mla, mlc}, mh);
    tag_q.push_back(t);
  endtask

  task automatic wait_tag(input string name);
    int w = 0;
    while (!oTagValid && w < 10) begin
      @(negedge iClk);
      w++;
    end
    check(name, oTagValid, 1);
    $display("tag %s oTag=%h oErr=%0d", name, oTag, oErr);
  endtask

  localparam logic [0:127] H_TC2  = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [0:127] C_TC2  = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [0:127] Y_TC2  = 128'h5E2EC746917062882C85B0685353DEB7;
  localparam logic [0:127] T_TC2  = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;
  localparam logic [0:127] H_P    = 128'h73A23D80121DE2D5A850253FCF43120E;

  logic [0:127] pd [5];
  logic [4:0]   pb [5];
  logic         pt [5];
  logic [0:127] py [5];

  task automatic run_partial(input bit gaps, output logic [0:127] t);
    do_start(H_P, 1'b0);
    for (int i = 0; i < 5; i++)
      send_block(pd[i], pb[i], pt[i], i == 4, gaps ? $urandom_range(0, 3) : 0, 1'b1, py[i],
                 $sformatf("partial_y%0d", i));
    push_tag(1'b0, '0, t);
    wait_tag("partial_tag_wait");
  endtask

  initial begin
    logic [0:127] t, t2;
    pd[0] = 128'hD609B1F056637A0D46DF998D88E52E00; pb[0] = 5'd16; pt[0] = 1'b0;
    pd[1] = 128'hB2C2846512153524C0895E81DEADBEEF; pb[1] = 5'd12; pt[1] = 1'b0;
    pd[2] = 128'h701AFA1CC039C0D765128A665DAB6924; pb[2] = 5'd16; pt[2] = 1'b1;
    pd[3] = 128'h3899BF7318CCDC81C9931DA17FBE8EDD; pb[3] = 5'd16; pt[3] = 1'b1;
    pd[4] = 128'h7D17CB8B4C26FC81E3284F2B7FBA713D; pb[4] = 5'd16; pt[4] = 1'b1;
    py[0] = 128'h9CABBD91899C1413AA7AD629C1DF12CD;
    py[1] = 128'hB99ABF6BDBD18B8E148F8030F0686F28;
    py[2] = 128'h8B5BD74B9A65A459150392C3872BCE7F;
    py[3] = 128'h934E9D58C59230EE652675D0FF4FB255;
    py[4] = 128'h4738D208B10FAFF24D6DFBDDC916DC44;

    iRst = 1'b1; iStart = 1'b0; iHashkey = '0; iData = '0; iBytes = 5'd16;
    iType = 1'b0; iLast = 1'b0; iValid = 1'b0;
    mh = '0; my = '0; mla = '0; mlc = '0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    check("rst_hash", oHash, '0);
    check("rst_tag", oTag, '0);
    check("rst_flags", {oReady, oTagValid, oErr}, 3'b000);

    // GCM test case 2
    do_start(H_TC2, 1'b0);
    check("start_ready", oReady, 1);
    send_block(C_TC2, 5'd16, 1'b1, 1'b1, 0, 1'b1, Y_TC2, "tc2_y1");
    push_tag(1'b1, T_TC2, t);
    wait_tag("tc2_tag_wait");
    check("tc2_err", oErr, 0);

    // Partial AAD message, then the same with idle gaps
    run_partial(1'b0, t);
    run_partial(1'b1, t2);
    check("gap_tag_same", t2, t);
    repeat (3) begin
      @(negedge iClk);
      iValid = 1'b1; iData = {$urandom, $urandom, $urandom, $urandom}; iLast = 1'b1;
    end
    @(negedge iClk);
    iValid = 1'b0;
    check("done_hold_tag", oTag, t);
    check("done_hold_valid", oTagValid, 1);

    // Abort mid-message; the start cycle also carries a block that must be dropped
    do_start(H_P, 1'b0);
    send_block(pd[0], 5'd16, 1'b0, 1'b0, 0, 1'b0, '0, "abort_b0");
    send_block(pd[1], 5'd16, 1'b0, 1'b0, 0, 1'b0, '0, "abort_b1");
    do_start(H_TC2, 1'b1);
    send_block(C_TC2, 5'd16, 1'b1, 1'b1, 0, 1'b1, Y_TC2, "abort_tc2_y1");
    push_tag(1'b1, T_TC2, t);
    wait_tag("abort_tag_wait");
    check("abort_err", oErr, 0);

    // AAD after CT
    do_start(H_P, 1'b0);
    send_block(pd[2], 5'd16, 1'b1, 1'b0, 0, 1'b0, '0, "err_ct");
    @(negedge iClk);
    check("err_clean", oErr, 0);
    send_block(pd[0], 5'd16, 1'b0, 1'b1, 0, 1'b0, '0, "err_aad_after_ct");
    push_tag(1'b0, '0, t);
    wait_tag("err_order_tag_wait");
    check("err_order", oErr, 1);
    repeat (2) @(negedge iClk);
    check("err_sticky", oErr, 1);
    do_start(H_P, 1'b0);
    @(negedge iClk);
    check("err_cleared", oErr, 0);
    check("start_clears_tv", oTagValid, 0);

    // Zero byte count
    send_block(pd[3], 5'd0, 1'b1, 1'b1, 0, 1'b0, '0, "err_bytes0");
    push_tag(1'b0, '0, t);
    wait_tag("err_bytes0_tag_wait");
    check("err_bytes0", oErr, 1);

    // Partial AAD block not flagged last, followed by another AAD block
    do_start(H_TC2, 1'b0);
    send_block(pd[0], 5'd5, 1'b0, 1'b0, 0, 1'b0, '0, "part_aad5");
    @(negedge iClk);
    check("part_no_err_yet", oErr, 0);
    send_block(pd[1], 5'd16, 1'b0, 1'b1, 0, 1'b0, '0, "part_aad_next");
    push_tag(1'b0, '0, t);
    wait_tag("part_tag_wait");
    check("err_partial", oErr, 1);

    // Reset while in LEN with the error flag set
    do_start(H_P, 1'b0);
    send_block(pd[4], 5'd0, 1'b1, 1'b1, 0, 1'b0, '0, "rst_len_blk");
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    check("rstlen_hash", oHash, '0);
    check("rstlen_tag", oTag, '0);
    check("rstlen_flags", {oReady, oTagValid, oErr}, 3'b000);
    iValid = 1'b1; iData = pd[0]; iLast = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    check("idle_ignores_hash", oHash, '0);
    check("idle_ready", oReady, 0);

    repeat (2) @(negedge iClk);
    check("queues_empty", 128'(hash_q.size() + tag_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog");
  end

endmodule
